// File: rtl/int_ctrl.sv
// Interrupt controller: captures int_src into pending, masks them, raises one fixed-priority irq (lowest index wins).
// Latency: pending 1 cycle after the input edge, irq 1 cycle after eligible appears; bus reads are combinational.
// Backpressure: none; the CPU paces service via VEC read (acknowledge) and the EOI write. Option macro: INT_CTRL_LEVEL_EN.
module int_ctrl #(
    parameter int N_SRC = 4
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             we,
    input  logic [15:0]      adrs,
    input  logic [15:0]      from_cpu,
    output logic [15:0]      to_cpu,
    input  logic [N_SRC-1:0] int_src,
    output logic             irq
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] lowbit;
    logic             gie;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [3:0]       isr_idx;
    logic [3:0]       idx;
    logic             valid;
    logic             rd_en;
    logic             wr_en;
    logic             ack;
    logic             eoi;

    assign rd_en = cs & ~we;
    assign wr_en = cs & we;

    // Fixed-priority arbitration: isolate the lowest eligible bit and encode it.
    always_comb begin
        eligible = pending & mask & {N_SRC{gie}};
        lowbit   = eligible & (~eligible + N_SRC'(1));
        valid    = |eligible;
        idx      = 4'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (lowbit[i]) idx = 4'(i);
        end
    end

    // A VEC read only acknowledges while an interrupt is actually being presented.
    assign ack = rd_en && (adrs[1:0] == 2'd2) && (state == ST_ACTIVE) && valid;
    assign eoi = wr_en && (adrs[1:0] == 2'd3) && from_cpu[1];

    // Next-state logic; losing eligibility in ACTIVE takes precedence over an acknowledge.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:    state_nxt = valid ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: begin
                if (!valid)   state_nxt = ST_IDLE;
                else if (ack) state_nxt = ST_SERVICE;
                else          state_nxt = ST_ACTIVE;
            end
            ST_SERVICE: state_nxt = eoi ? ST_IDLE : ST_SERVICE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State, registered irq (mirrors ACTIVE) and the index latched at acknowledge.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            irq     <= 1'b0;
            isr_idx <= 4'd0;
        end else begin
            state <= state_nxt;
            irq   <= (state_nxt == ST_ACTIVE);
            if (ack) isr_idx <= idx;
        end
    end

    // Mask and global-enable registers; EOI bit of the CTRL write is a strobe, not stored.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            mask <= '0;
            gie  <= 1'b0;
        end else if (wr_en) begin
            if (adrs[1:0] == 2'd1) mask <= from_cpu[N_SRC-1:0];
            if (adrs[1:0] == 2'd3) gie  <= from_cpu[0];
        end
    end

`ifdef INT_CTRL_LEVEL_EN
    // Level mode: pending simply follows the request lines; the peripheral owns clearing.
    always_ff @(posedge cpu_clk) begin
        if (rst) pending <= '0;
        else     pending <= int_src;
    end
`else
    logic [N_SRC-1:0] src_d;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;

    // Clear sources: W1C writes to PEND and the acknowledged source.
    always_comb begin
        w1c     = (wr_en && (adrs[1:0] == 2'd0)) ? from_cpu[N_SRC-1:0] : '0;
        ack_clr = ack ? lowbit : '0;
    end

    // Rising-edge capture; a new edge overrides a same-cycle clear so no request is lost.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            src_d   <= '0;
            pending <= '0;
        end else begin
            src_d   <= int_src;
            pending <= (pending & ~w1c & ~ack_clr) | (int_src & ~src_d);
        end
    end
`endif

    // Combinational read mux; bus idles at zero when not reading.
    always_comb begin
        to_cpu = 16'h0000;
        if (rd_en) begin
            case (adrs[1:0])
                2'd0:    to_cpu = 16'(pending);
                2'd1:    to_cpu = 16'(mask);
                2'd2:    to_cpu = {valid, 11'h000, idx};
                default: to_cpu = {13'h0000, (state == ST_SERVICE), irq, gie};
            endcase
        end
    end

    // Address/data bits outside the decoded fields and the held service index are not read back.
    logic unused_bits;
    assign unused_bits = ^{adrs[15:2], from_cpu[15:2], isr_idx};

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed bus sequences push expected values into queues,
// a negedge monitor pops and compares on every bus read and every irq probe.
// Build with INT_CTRL_LEVEL_EN defined to exercise level-sensitive sources.
module tb_int_ctrl;

    typedef struct {
        string       nm;
        logic [15:0] v;
    } exp_t;

    logic        cpu_clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [15:0] adrs;
    logic [15:0] from_cpu;
    logic [15:0] to_cpu;
    logic [3:0]  int_src;
    logic        irq;

    logic        probe = 1'b0;
    exp_t        q_rd[$];
    exp_t        q_irq[$];
    int          n_vec = 0;
    int          n_err = 0;

    int_ctrl #(.N_SRC(4)) dut (
        .cpu_clk  (cpu_clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .adrs     (adrs),
        .from_cpu (from_cpu),
        .to_cpu   (to_cpu),
        .int_src  (int_src),
        .irq      (irq)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Monitor: compare on the falling edge whenever the DUT presents read data or irq is probed.
    always @(negedge cpu_clk) begin
        exp_t e;
        if (probe) begin
            n_vec++;
            if (q_irq.size() == 0) begin
                n_err++;
                $display("FAIL irq_probe: no expectation queued, irq=%0b", irq);
            end else begin
                e = q_irq.pop_front();
                if (irq !== e.v[0]) begin
                    n_err++;
                    $display("FAIL %s: irq=%0b expected %0b", e.nm, irq, e.v[0]);
                end
            end
        end
        if (cs === 1'b1 && we === 1'b0) begin
            n_vec++;
            if (q_rd.size() == 0) begin
                n_err++;
                $display("FAIL bus_read: no expectation queued, to_cpu=%h", to_cpu);
            end else begin
                e = q_rd.pop_front();
                if (to_cpu !== e.v) begin
                    n_err++;
                    $display("FAIL %s: to_cpu=%h expected %h", e.nm, to_cpu, e.v);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge cpu_clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic exp_irq(input logic v, input string nm);
        exp_t e;
        e.nm = nm;
        e.v  = {15'h0000, v};
        q_irq.push_back(e);
        probe = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] v, input string nm);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q_rd.push_back(e);
        cs   = 1'b1;
        we   = 1'b0;
        adrs = {14'h0000, a};
        cyc();
        cs   = 1'b0;
        adrs = 16'h0000;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cs       = 1'b1;
        we       = 1'b1;
        adrs     = {14'h0000, a};
        from_cpu = d;
        cyc();
        cs       = 1'b0;
        we       = 1'b0;
        adrs     = 16'h0000;
        from_cpu = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cs = 1'b0; we = 1'b0; adrs = 16'h0000; from_cpu = 16'h0000; int_src = 4'h0;
        idle(2);
        rst = 1'b0;

        // Reset state
        exp_irq(1'b0, "rst_irq");
        rd(2'd0, 16'h0000, "rst_pend");
        rd(2'd1, 16'h0000, "rst_mask");
        rd(2'd3, 16'h0000, "rst_ctrl");
        rd(2'd2, 16'h0000, "rst_vec");

`ifdef INT_CTRL_LEVEL_EN
        // Level: request held across ack and EOI re-raises irq
        wr(2'd1, 16'h000F);
        wr(2'd3, 16'h0001);
        int_src = 4'b0010;
        cyc();
        exp_irq(1'b0, "lvl_pre_irq");
        cyc();
        exp_irq(1'b1, "lvl_irq");
        rd(2'd2, 16'h8001, "lvl_vec_ack");
        rd(2'd0, 16'h0002, "lvl_pend_kept");
        rd(2'd3, 16'h0005, "lvl_ctrl_svc");
        wr(2'd3, 16'h0003);
        exp_irq(1'b0, "lvl_eoi_gap");
        cyc();
        exp_irq(1'b1, "lvl_reraise");
        rd(2'd2, 16'h8001, "lvl_vec_ack2");
        // Request dropped before EOI: irq stays low
        int_src = 4'b0000;
        cyc();
        wr(2'd3, 16'h0003);
        exp_irq(1'b0, "lvl_after_eoi");
        cyc();
        exp_irq(1'b0, "lvl_stay_low");
        rd(2'd0, 16'h0000, "lvl_pend_clear");
`else
        // Basic flow on source 2
        wr(2'd1, 16'h000F);
        wr(2'd3, 16'h0001);
        int_src = 4'b0100;
        cyc();
        int_src = 4'b0000;
        exp_irq(1'b0, "pre_irq");
        cyc();
        exp_irq(1'b1, "irq_raise");
        rd(2'd2, 16'h8002, "vec_ack");
        exp_irq(1'b0, "irq_after_ack");
        rd(2'd0, 16'h0000, "pend_after_ack");
        rd(2'd3, 16'h0005, "ctrl_service");
        wr(2'd3, 16'h0003);
        rd(2'd3, 16'h0001, "ctrl_after_eoi");

        // Priority: sources 1 and 3 together, lowest first
        int_src = 4'b1010;
        cyc();
        int_src = 4'b0000;
        cyc();
        exp_irq(1'b1, "prio_irq");
        rd(2'd2, 16'h8001, "prio_vec1");
        rd(2'd0, 16'h0008, "prio_pend3");
        wr(2'd3, 16'h0003);
        exp_irq(1'b0, "prio_eoi_gap");
        cyc();
        exp_irq(1'b1, "prio_reraise");
        rd(2'd2, 16'h8003, "prio_vec3");
        wr(2'd3, 16'h0003);

        // Mask and gie gating on source 0
        wr(2'd1, 16'h0000);
        int_src = 4'b0001;
        cyc();
        int_src = 4'b0000;
        idle(2);
        exp_irq(1'b0, "masked_irq");
        rd(2'd0, 16'h0001, "masked_pend");
        wr(2'd1, 16'h0001);
        rd(2'd2, 16'h8000, "vec_idle_plain");
        exp_irq(1'b1, "unmask_irq");
        rd(2'd0, 16'h0001, "pend_not_acked");
        wr(2'd3, 16'h0000);
        exp_irq(1'b1, "gie_off_lag");
        cyc();
        exp_irq(1'b0, "gie_off_irq");
        wr(2'd0, 16'h0001);
        rd(2'd0, 16'h0000, "pend_w1c");

        // Same-cycle set and W1C: set wins
        int_src = 4'b0001;
        wr(2'd0, 16'h0001);
        int_src = 4'b0000;
        rd(2'd0, 16'h0001, "set_wins");
        wr(2'd0, 16'h0001);
        rd(2'd0, 16'h0000, "w1c_clear");

        // Reset mid-operation; pulse during reset is lost
        wr(2'd3, 16'h0001);
        int_src = 4'b0001;
        cyc();
        int_src = 4'b0000;
        cyc();
        exp_irq(1'b1, "pre_reset_irq");
        rst = 1'b1;
        int_src = 4'b0010;
        cyc();
        rst = 1'b0;
        int_src = 4'b0000;
        exp_irq(1'b0, "mid_rst_irq");
        rd(2'd0, 16'h0000, "mid_rst_pend");
        rd(2'd1, 16'h0000, "mid_rst_mask");
        rd(2'd3, 16'h0000, "mid_rst_ctrl");
        cyc();
        rd(2'd0, 16'h0000, "rst_edge_lost");
`endif

        idle(2);
        if (q_rd.size() != 0 || q_irq.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expectations: rd=%0d irq=%0d still queued, required 0",
                     q_rd.size(), q_irq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
